// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit/receive blocks.
package serial_pkg;

   localparam int unsigned CLOCKS_WAIT_DEFAULT = 434;
   localparam int          BAUD_CNT_W          = 12;
   localparam int          BIT_IDX_W           = 4;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_e;

endpackage

// File: rtl/serial_baud_counter.sv
// Bit-period counter: counts 0..CLOCKS_WAIT-1, tick marks the last cycle of a bit.
module serial_baud_counter
   import serial_pkg::*;
#(
   parameter int unsigned CLOCKS_WAIT = CLOCKS_WAIT_DEFAULT
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam logic [BAUD_CNT_W-1:0] TERM_CNT = BAUD_CNT_W'(CLOCKS_WAIT - 1);

   logic [BAUD_CNT_W-1:0] count_q;
   logic [BAUD_CNT_W-1:0] count_d;

   assign tick = (count_q == TERM_CNT);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = tick ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/serial_transmitter.sv
// UART transmit engine, LSB-first, idle-high line, registered outputs.
// Optional even parity bit after bit 7 when SERIAL_TX_PARITY_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------
// TX_IDLE   | line high, READY high, waiting for IN_SEND
// TX_START  | start bit (0) for one bit period
// TX_DATA   | data bits 0..7, one bit period each
// TX_PARITY | even parity of the byte (parity build only)
// TX_STOP   | stop bit(s) (1), STOP_BITS bit periods
module serial_transmitter
   import serial_pkg::*;
#(
   parameter int unsigned CLOCKS_WAIT = CLOCKS_WAIT_DEFAULT,
   parameter int unsigned STOP_BITS   = 1
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [7:0] IN_DATA,
   input  logic       IN_SEND,
   output logic       OUT_SERIAL_TX,
   output logic       OUT_STATUS_READY
);

   localparam logic [BIT_IDX_W-1:0] LAST_BIT  = 4'd7;
   localparam logic                 STOP_LAST = 1'(STOP_BITS - 1);

   tx_state_e              state_q, state_d;
   logic [7:0]             shift_q, shift_d;
   logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
   logic                   stop_cnt_q, stop_cnt_d;
   logic                   tx_q, tx_d;
   logic                   ready_q, ready_d;
   logic                   tick;
   logic                   accept;
   logic                   parity_bit;

   assign accept = (state_q == TX_IDLE) && IN_SEND;

   serial_baud_counter #(
      .CLOCKS_WAIT (CLOCKS_WAIT)
   ) u_baud (
      .clk_sys (CLK),
      .rst_b   (RESET_N),
      .clear   (state_q == TX_IDLE),
      .enable  (1'b1),
      .tick    (tick)
   );

`ifdef SERIAL_TX_PARITY_EN
   logic parity_q, parity_d;

   always_comb begin
      parity_d = accept ? ^IN_DATA : parity_q;
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign parity_bit = parity_q;
`else
   assign parity_bit = 1'b1;
`endif

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q    <= TX_IDLE;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         stop_cnt_q <= 1'b0;
         tx_q       <= 1'b1;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
         ready_q    <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         TX_IDLE:  if (IN_SEND) state_d = TX_START;
         TX_START: if (tick) state_d = TX_DATA;
         TX_DATA: begin
            if (tick && (bit_idx_q == LAST_BIT)) begin
`ifdef SERIAL_TX_PARITY_EN
               state_d = TX_PARITY;
`else
               state_d = TX_STOP;
`endif
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         TX_PARITY: if (tick) state_d = TX_STOP;
`endif
         TX_STOP:  if (tick && (stop_cnt_q == STOP_LAST)) state_d = TX_IDLE;
         default:  state_d = TX_IDLE;
      endcase
   end

   // Line level is a pure function of the next state, so tx_q never glitches.
   always_comb begin
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      stop_cnt_d = 1'b0;
      if (accept) begin
         shift_d = IN_DATA;
      end
      if (state_q == TX_START) begin
         bit_idx_d = '0;
      end
      if ((state_q == TX_DATA) && tick && (bit_idx_q != LAST_BIT)) begin
         shift_d   = shift_q >> 1;
         bit_idx_d = bit_idx_q + 1'b1;
      end
      if (state_q == TX_STOP) begin
         stop_cnt_d = tick ? stop_cnt_q + 1'b1 : stop_cnt_q;
      end

      ready_d = (state_d == TX_IDLE);
      case (state_d)
         TX_START:  tx_d = 1'b0;
         TX_DATA:   tx_d = shift_d[0];
         TX_PARITY: tx_d = parity_bit;
         default:   tx_d = 1'b1;
      endcase
   end

   assign OUT_SERIAL_TX    = tx_q;
   assign OUT_STATUS_READY = ready_q;

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench for serial_transmitter with CLOCKS_WAIT=4, one and two stop bits.
module tb_serial_transmitter;

   localparam int CW = 4;
`ifdef SERIAL_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int LEN1 = (9 + PAR + 1) * CW;
   localparam int LEN2 = (9 + PAR + 2) * CW;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_send;
   logic       in_send2;
   logic       tx1, rdy1, tx2, rdy2;

   int errors = 0;
   int checks = 0;

   logic tx_log  [0:127];
   logic rdy_log [0:127];

   serial_transmitter #(.CLOCKS_WAIT(CW), .STOP_BITS(1)) dut (
      .CLK              (clk),
      .RESET_N          (rst_n),
      .IN_DATA          (in_data),
      .IN_SEND          (in_send),
      .OUT_SERIAL_TX    (tx1),
      .OUT_STATUS_READY (rdy1)
   );

   serial_transmitter #(.CLOCKS_WAIT(CW), .STOP_BITS(2)) dut2 (
      .CLK              (clk),
      .RESET_N          (rst_n),
      .IN_DATA          (in_data),
      .IN_SEND          (in_send2),
      .OUT_SERIAL_TX    (tx2),
      .OUT_STATUS_READY (rdy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic exp_bit(input logic [7:0] data, input int j);
      int b;
      b = j / CW;
      if (b == 0) return 1'b0;
      if (b <= 8) return data[b-1];
      if (PAR == 1 && b == 9) return ^data;
      return 1'b1;
   endfunction

   function automatic int shape_errs(input int off, input logic [7:0] data, input int len);
      int n;
      n = 0;
      for (int j = 0; j < len; j++)
         if (tx_log[off+j] !== exp_bit(data, j)) n++;
      return n;
   endfunction

   function automatic logic [7:0] decode(input int off);
      logic [7:0] d;
      for (int b = 0; b < 8; b++) d[b] = tx_log[off + (1+b)*CW + CW/2];
      return d;
   endfunction

   function automatic int ready_len(input int off, input int n);
      int c;
      c = 0;
      while ((off + c < n) && (rdy_log[off+c] === 1'b0)) c++;
      return c;
   endfunction

   task automatic set_send(input int which, input logic v);
      if (which == 1) in_send2 = v;
      else            in_send  = v;
   endtask

   // Leaves the bench at the negedge right after the accept edge.
   task automatic start_frame(input int which, input logic [7:0] data, input bit hold);
      @(negedge clk);
      in_data = data;
      set_send(which, 1'b1);
      @(negedge clk);
      if (!hold) set_send(which, 1'b0);
   endtask

   // Sample j is taken after accept edge + j; first sample at the current negedge.
   task automatic capture(input int which, input int n, input int on_j, input int off_j,
                          input int rst_j);
      for (int j = 0; j < n; j++) begin
         if (j > 0) @(negedge clk);
         tx_log[j]  = (which == 1) ? tx2  : tx1;
         rdy_log[j] = (which == 1) ? rdy2 : rdy1;
         if (j == on_j) begin
            in_data = 8'hFF;
            set_send(which, 1'b1);
         end
         if (j == off_j) set_send(which, 1'b0);
         if (j == rst_j) rst_n = 1'b0;
         if (j == rst_j + 1) rst_n = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (tx1 !== 1'b1) begin errors++; $display("FAIL reset_tx1 got=%b exp=1", tx1); end
      checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_rdy1 got=%b exp=1", rdy1); end
      checks++; if (tx2 !== 1'b1) begin errors++; $display("FAIL reset_tx2 got=%b exp=1", tx2); end
      checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL reset_rdy2 got=%b exp=1", rdy2); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if ({tx1, rdy1} !== 2'b11) begin errors++; $display("FAIL idle_after_reset got=%b exp=11", {tx1, rdy1}); end
   endtask

   task automatic test_single_frame();
      int e;
      start_frame(0, 8'h55, 1'b0);
      capture(0, LEN1 + 2, -1, -1, -1);
      e = shape_errs(0, 8'h55, LEN1);
      checks++; if (e != 0) begin errors++; $display("FAIL f55_shape bad_cycles=%0d exp=0", e); end
      checks++; if (decode(0) !== 8'h55) begin errors++; $display("FAIL f55_byte got=%h exp=55", decode(0)); end
      checks++; if (ready_len(0, LEN1 + 2) != LEN1) begin errors++; $display("FAIL f55_ready_low got=%0d exp=%0d", ready_len(0, LEN1 + 2), LEN1); end
      checks++; if ({tx_log[LEN1+1], rdy_log[LEN1+1]} !== 2'b11) begin errors++; $display("FAIL f55_idle got=%b exp=11", {tx_log[LEN1+1], rdy_log[LEN1+1]}); end
   endtask

   task automatic test_back_to_back();
      int e;
      int off2;
      off2 = LEN1 + 1;
      start_frame(0, 8'hA5, 1'b1);
      in_data = 8'h3C;
      capture(0, 2*LEN1 + 2, -1, off2, -1);
      e = shape_errs(0, 8'hA5, LEN1);
      checks++; if (e != 0) begin errors++; $display("FAIL b2b_a5_shape bad_cycles=%0d exp=0", e); end
      checks++; if (decode(0) !== 8'hA5) begin errors++; $display("FAIL b2b_a5_byte got=%h exp=a5", decode(0)); end
      checks++; if ({tx_log[LEN1], rdy_log[LEN1]} !== 2'b11) begin errors++; $display("FAIL b2b_gap got=%b exp=11", {tx_log[LEN1], rdy_log[LEN1]}); end
      checks++; if (rdy_log[off2] !== 1'b0) begin errors++; $display("FAIL b2b_second_accept got=%b exp=0", rdy_log[off2]); end
      e = shape_errs(off2, 8'h3C, LEN1);
      checks++; if (e != 0) begin errors++; $display("FAIL b2b_3c_shape bad_cycles=%0d exp=0", e); end
      checks++; if (decode(off2) !== 8'h3C) begin errors++; $display("FAIL b2b_3c_byte got=%h exp=3c", decode(off2)); end
      checks++; if (ready_len(off2, 2*LEN1 + 2) != LEN1) begin errors++; $display("FAIL b2b_3c_ready_low got=%0d exp=%0d", ready_len(off2, 2*LEN1 + 2), LEN1); end
   endtask

   task automatic test_ignore_busy();
      int e;
      start_frame(0, 8'h0F, 1'b0);
      capture(0, LEN1 + 3, 10, 30, -1);
      e = shape_errs(0, 8'h0F, LEN1);
      checks++; if (e != 0) begin errors++; $display("FAIL busy_shape bad_cycles=%0d exp=0", e); end
      checks++; if (decode(0) !== 8'h0F) begin errors++; $display("FAIL busy_byte got=%h exp=0f", decode(0)); end
      checks++; if (ready_len(0, LEN1 + 3) != LEN1) begin errors++; $display("FAIL busy_ready_low got=%0d exp=%0d", ready_len(0, LEN1 + 3), LEN1); end
      checks++; if ({tx_log[LEN1+2], rdy_log[LEN1+2]} !== 2'b11) begin errors++; $display("FAIL busy_no_queue got=%b exp=11", {tx_log[LEN1+2], rdy_log[LEN1+2]}); end
   endtask

   task automatic test_mid_reset();
      int e;
      int rj;
      rj = 4*CW + 1;
      start_frame(0, 8'h00, 1'b0);
      capture(0, rj + 4, -1, -1, rj);
      checks++; if ({tx_log[rj], rdy_log[rj]} !== 2'b00) begin errors++; $display("FAIL rst_before got=%b exp=00", {tx_log[rj], rdy_log[rj]}); end
      checks++; if ({tx_log[rj+1], rdy_log[rj+1]} !== 2'b11) begin errors++; $display("FAIL rst_abort got=%b exp=11", {tx_log[rj+1], rdy_log[rj+1]}); end
      checks++; if ({tx_log[rj+3], rdy_log[rj+3]} !== 2'b11) begin errors++; $display("FAIL rst_stays_idle got=%b exp=11", {tx_log[rj+3], rdy_log[rj+3]}); end
      start_frame(0, 8'h81, 1'b0);
      capture(0, LEN1 + 2, -1, -1, -1);
      e = shape_errs(0, 8'h81, LEN1);
      checks++; if (e != 0) begin errors++; $display("FAIL rst_81_shape bad_cycles=%0d exp=0", e); end
      checks++; if (decode(0) !== 8'h81) begin errors++; $display("FAIL rst_81_byte got=%h exp=81", decode(0)); end
      checks++; if (ready_len(0, LEN1 + 2) != LEN1) begin errors++; $display("FAIL rst_81_ready_low got=%0d exp=%0d", ready_len(0, LEN1 + 2), LEN1); end
   endtask

   task automatic test_two_stop_bits();
      int e;
      start_frame(1, 8'h00, 1'b0);
      capture(1, LEN2 + 2, -1, -1, -1);
      e = shape_errs(0, 8'h00, LEN2);
      checks++; if (e != 0) begin errors++; $display("FAIL stop2_shape bad_cycles=%0d exp=0", e); end
      checks++; if (decode(0) !== 8'h00) begin errors++; $display("FAIL stop2_byte got=%h exp=00", decode(0)); end
      checks++; if (ready_len(0, LEN2 + 2) != LEN2) begin errors++; $display("FAIL stop2_ready_low got=%0d exp=%0d", ready_len(0, LEN2 + 2), LEN2); end
      checks++; if (tx_log[LEN2-1] !== 1'b1) begin errors++; $display("FAIL stop2_last_stop got=%b exp=1", tx_log[LEN2-1]); end
   endtask

`ifdef SERIAL_TX_PARITY_EN
   task automatic test_parity();
      int e;
      start_frame(0, 8'h07, 1'b0);
      capture(0, LEN1 + 2, -1, -1, -1);
      checks++; if (tx_log[9*CW + 1] !== 1'b1) begin errors++; $display("FAIL par07_bit got=%b exp=1", tx_log[9*CW + 1]); end
      e = shape_errs(0, 8'h07, LEN1);
      checks++; if (e != 0) begin errors++; $display("FAIL par07_shape bad_cycles=%0d exp=0", e); end
      start_frame(0, 8'h03, 1'b0);
      capture(0, LEN1 + 2, -1, -1, -1);
      checks++; if (tx_log[9*CW + 1] !== 1'b0) begin errors++; $display("FAIL par03_bit got=%b exp=0", tx_log[9*CW + 1]); end
      checks++; if (ready_len(0, LEN1 + 2) != 44) begin errors++; $display("FAIL par03_len got=%0d exp=44", ready_len(0, LEN1 + 2)); end
   endtask
`endif

   initial begin
      rst_n    = 1'b0;
      in_data  = 8'h00;
      in_send  = 1'b0;
      in_send2 = 1'b0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_ignore_busy();
      test_mid_reset();
      test_two_stop_bits();
`ifdef SERIAL_TX_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
